// File: rtl/sram_arbiter_if.sv
// SNES / MCU / SRAM0 signal bundle for sram_arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and models the chip.
interface sram_arbiter_if;
    logic        SNES_RD_START;
    logic        SNES_WR_START;
    logic [23:0] SNES_ROM_ADDR;
    logic        SNES_ROM_HIT;
    logic        SNES_IS_WRITABLE;
    logic [7:0]  SNES_WRDATA;
    logic [7:0]  SNES_RDDATA;
    logic        SNES_DATA_VALID;

    logic        MCU_RRQ;
    logic        MCU_WRQ;
    logic [23:0] MCU_ADDR;
    logic [7:0]  MCU_WRDATA;
    logic [7:0]  MCU_RDDATA;
    logic        MCU_RDY;

    logic [23:0] ROM_ADDR;
    logic [7:0]  ROM_DOUT;
    logic        ROM_DOE;
    logic [7:0]  ROM_DIN;
    logic        ROM_CE_N;
    logic        ROM_OE_N;
    logic        ROM_WE_N;

    modport slave (
        input  SNES_RD_START, SNES_WR_START, SNES_ROM_ADDR, SNES_ROM_HIT,
               SNES_IS_WRITABLE, SNES_WRDATA,
        output SNES_RDDATA, SNES_DATA_VALID,
        input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_WRDATA,
        output MCU_RDDATA, MCU_RDY,
        output ROM_ADDR, ROM_DOUT, ROM_DOE, ROM_CE_N, ROM_OE_N, ROM_WE_N,
        input  ROM_DIN
    );

    modport master (
        output SNES_RD_START, SNES_WR_START, SNES_ROM_ADDR, SNES_ROM_HIT,
               SNES_IS_WRITABLE, SNES_WRDATA,
        input  SNES_RDDATA, SNES_DATA_VALID,
        output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_WRDATA,
        input  MCU_RDDATA, MCU_RDY,
        input  ROM_ADDR, ROM_DOUT, ROM_DOE, ROM_CE_N, ROM_OE_N, ROM_WE_N,
        output ROM_DIN
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the SRAM0 chip between SNES bus and MCU: SNES first, fixed-width strobes,
// one idle turnaround cycle after every access.
module sram_arbiter #(
    parameter int RD_CYCLES = 5,
    parameter int WR_CYCLES = 4
) (
    input logic           CLK,
    input logic           RST_N,
    sram_arbiter_if.slave bus
);
    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        snes_pend_q, snes_pend_d;
    logic        snes_wr_q, snes_wr_d;
    logic [23:0] snes_addr_q, snes_addr_d;
    logic [7:0]  snes_data_q, snes_data_d;
    logic        mcu_wpend_q, mcu_wpend_d;
    logic [23:0] mcu_waddr_q, mcu_waddr_d;
    logic [7:0]  mcu_wdata_q, mcu_wdata_d;
    logic        mcu_rpend_q, mcu_rpend_d;
    logic [23:0] mcu_raddr_q, mcu_raddr_d;

    logic [23:0] rom_addr_q, rom_addr_d;
    logic [7:0]  rom_dout_q, rom_dout_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        doe_q, doe_d;
    logic [7:0]  snes_rddata_q, snes_rddata_d;
    logic        snes_valid_q, snes_valid_d;
    logic [7:0]  mcu_rddata_q, mcu_rddata_d;
    logic        mcu_rdy_q, mcu_rdy_d;

    logic        last;
    logic        is_rd_d, is_wr_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        snes_pend_d   = snes_pend_q;
        snes_wr_d     = snes_wr_q;
        snes_addr_d   = snes_addr_q;
        snes_data_d   = snes_data_q;
        mcu_wpend_d   = mcu_wpend_q;
        mcu_waddr_d   = mcu_waddr_q;
        mcu_wdata_d   = mcu_wdata_q;
        mcu_rpend_d   = mcu_rpend_q;
        mcu_raddr_d   = mcu_raddr_q;
        rom_addr_d    = rom_addr_q;
        rom_dout_d    = rom_dout_q;
        snes_rddata_d = snes_rddata_q;
        mcu_rddata_d  = mcu_rddata_q;
        snes_valid_d  = 1'b0;
        mcu_rdy_d     = 1'b0;
        last          = (cnt_q == 8'd0);

        // SNES slot is one deep and the newest start replaces it; read beats write.
        if (bus.SNES_RD_START && bus.SNES_ROM_HIT) begin
            snes_pend_d = 1'b1;
            snes_wr_d   = 1'b0;
            snes_addr_d = bus.SNES_ROM_ADDR;
        end else if (bus.SNES_WR_START && bus.SNES_ROM_HIT && bus.SNES_IS_WRITABLE) begin
            snes_pend_d = 1'b1;
            snes_wr_d   = 1'b1;
            snes_addr_d = bus.SNES_ROM_ADDR;
            snes_data_d = bus.SNES_WRDATA;
        end

        // MCU slots keep the first request; repeats while pending are dropped.
        if (bus.MCU_WRQ && !mcu_wpend_q) begin
            mcu_wpend_d = 1'b1;
            mcu_waddr_d = bus.MCU_ADDR;
            mcu_wdata_d = bus.MCU_WRDATA;
        end
        if (bus.MCU_RRQ && !mcu_rpend_q) begin
            mcu_rpend_d = 1'b1;
            mcu_raddr_d = bus.MCU_ADDR;
        end

        unique case (state_q)
            IDLE: begin
                if (snes_pend_d) begin
                    state_d     = snes_wr_d ? SNES_WR : SNES_RD;
                    cnt_d       = snes_wr_d ? WR_LAST : RD_LAST;
                    rom_addr_d  = snes_addr_d;
                    if (snes_wr_d) begin
                        rom_dout_d = snes_data_d;
                    end
                    snes_pend_d = 1'b0;
                end else if (mcu_wpend_d) begin
                    state_d     = MCU_WR;
                    cnt_d       = WR_LAST;
                    rom_addr_d  = mcu_waddr_d;
                    rom_dout_d  = mcu_wdata_d;
                    mcu_wpend_d = 1'b0;
                end else if (mcu_rpend_d) begin
                    state_d     = MCU_RD;
                    cnt_d       = RD_LAST;
                    rom_addr_d  = mcu_raddr_d;
                    mcu_rpend_d = 1'b0;
                end
            end
            SNES_RD, MCU_RD: begin
                if (last) begin
                    state_d = IDLE;
                    if (state_q == SNES_RD) begin
                        snes_rddata_d = bus.ROM_DIN;
                        snes_valid_d  = 1'b1;
                    end else begin
                        mcu_rddata_d = bus.ROM_DIN;
                        mcu_rdy_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SNES_WR, MCU_WR: begin
                if (last) begin
                    state_d   = IDLE;
                    mcu_rdy_d = (state_q == MCU_WR);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with the counter.
        is_rd_d = (state_d == SNES_RD) || (state_d == MCU_RD);
        is_wr_d = (state_d == SNES_WR) || (state_d == MCU_WR);
        ce_n_d  = !(is_rd_d || is_wr_d);
        oe_n_d  = !is_rd_d;
        doe_d   = is_wr_d;
        // WE_N stays high in the first and last write cycle for address setup/hold.
        we_n_d  = !(is_wr_d && (cnt_d != 8'd0) && (cnt_d != WR_LAST));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            snes_pend_q   <= 1'b0;
            snes_wr_q     <= 1'b0;
            snes_addr_q   <= 24'd0;
            snes_data_q   <= 8'd0;
            mcu_wpend_q   <= 1'b0;
            mcu_waddr_q   <= 24'd0;
            mcu_wdata_q   <= 8'd0;
            mcu_rpend_q   <= 1'b0;
            mcu_raddr_q   <= 24'd0;
            rom_addr_q    <= 24'd0;
            rom_dout_q    <= 8'd0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            doe_q         <= 1'b0;
            snes_rddata_q <= 8'd0;
            snes_valid_q  <= 1'b0;
            mcu_rddata_q  <= 8'd0;
            mcu_rdy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            snes_pend_q   <= snes_pend_d;
            snes_wr_q     <= snes_wr_d;
            snes_addr_q   <= snes_addr_d;
            snes_data_q   <= snes_data_d;
            mcu_wpend_q   <= mcu_wpend_d;
            mcu_waddr_q   <= mcu_waddr_d;
            mcu_wdata_q   <= mcu_wdata_d;
            mcu_rpend_q   <= mcu_rpend_d;
            mcu_raddr_q   <= mcu_raddr_d;
            rom_addr_q    <= rom_addr_d;
            rom_dout_q    <= rom_dout_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            doe_q         <= doe_d;
            snes_rddata_q <= snes_rddata_d;
            snes_valid_q  <= snes_valid_d;
            mcu_rddata_q  <= mcu_rddata_d;
            mcu_rdy_q     <= mcu_rdy_d;
        end
    end

    assign bus.ROM_ADDR        = rom_addr_q;
    assign bus.ROM_DOUT        = rom_dout_q;
    assign bus.ROM_DOE         = doe_q;
    assign bus.ROM_CE_N        = ce_n_q;
    assign bus.ROM_OE_N        = oe_n_q;
    assign bus.ROM_WE_N        = we_n_q;
    assign bus.SNES_RDDATA     = snes_rddata_q;
    assign bus.SNES_DATA_VALID = snes_valid_q;
    assign bus.MCU_RDDATA      = mcu_rddata_q;
    assign bus.MCU_RDY         = mcu_rdy_q;
endmodule
